// File: rtl/mult_div_unit.sv
// ---------------------------------------------------------------------------
// mult_div_unit
//
// Iterative multiply/divide unit for the multicycle datapath. The control
// unit fires mult_start or div_start. The unit then works through the
// operation one bit per cycle and writes the result into the HI/LO
// registers. The mfhi/mflo paths read those registers.
//
//   multiply : radix-2 Booth, full 2*WIDTH-bit product in {hi, lo}
//   divide   : restoring division on magnitudes, followed by sign fix-up
//              lo = quotient (truncated toward zero)
//              hi = remainder (takes the sign of the dividend)
//
// Ports
//   clk          rising-edge clock
//   reset        synchronous, active-low reset
//   mult_start   start a multiply (only looked at while idle)
//   div_start    start a divide   (only looked at while idle)
//   a, b         operands (rs, rt), captured when the start is accepted
//   is_unsigned  operands are unsigned (only with MDU_UNSIGNED_EN)
//   busy         an operation is in flight
//   done         one-cycle pulse, hi/lo already hold the new result
//   div_zero     one-cycle pulse together with done for a divide by zero
//   hi, lo       result registers, held until the next result or reset
//
// Build option
//   MDU_UNSIGNED_EN  adds the is_unsigned port (multu/divu support).
//                    Without it every operation is signed.
// ---------------------------------------------------------------------------
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             mult_start,
  input  logic             div_start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef MDU_UNSIGNED_EN
  input  logic             is_unsigned,
`endif
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  typedef enum logic [2:0] {
    IDLE,
    MULT,
    DIV,
    FIX,
    DONE
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  // accHi is one bit wider than the operands. For Booth this keeps the
  // partial product exact even when the multiplicand is the most negative
  // value. For division it holds the partial remainder plus a sign bit for
  // the trial subtraction.
  logic [WIDTH:0]     accHi_q, accHi_d;
  logic [WIDTH-1:0]   accLo_q, accLo_d;
  logic [WIDTH-1:0]   operand_q, operand_d;
  logic               boothBit_q, boothBit_d;
  logic               opIsDiv_q, opIsDiv_d;
  logic               unsignedOp_q, unsignedOp_d;
  logic               negQuot_q, negQuot_d;
  logic               negRem_q, negRem_d;
  logic               divZero_q, divZero_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;

  logic               isUnsignedIn;
  logic               aNeg, bNeg;
  logic [WIDTH:0]     multExt;
  logic [WIDTH:0]     multSum;
  logic               shiftIn;
  logic [WIDTH:0]     remShifted;
  logic [WIDTH:0]     remTrial;
  logic               lastIter;

`ifdef MDU_UNSIGNED_EN
  assign isUnsignedIn = is_unsigned;
`else
  assign isUnsignedIn = 1'b0;
`endif

  // Operand signs at start time. In unsigned mode both are forced to zero,
  // so magnitude conversion and the later sign fix-up disappear.
  assign aNeg = ~isUnsignedIn & a[WIDTH-1];
  assign bNeg = ~isUnsignedIn & b[WIDTH-1];

  assign lastIter = (cnt_q == CNT_W'(WIDTH - 1));

  // Multiply step.
  // Signed mode uses Booth recoding on {multiplier LSB, previous LSB} and
  // an arithmetic shift.
  // Unsigned mode is a plain shift-add with a logical shift. The extra top
  // bit of accHi absorbs the carry from the add.
  always_comb begin
    multExt = unsignedOp_q ? {1'b0, operand_q} : {operand_q[WIDTH-1], operand_q};
    multSum = accHi_q;
    shiftIn = 1'b0;
    if (unsignedOp_q) begin
      if (accLo_q[0]) begin
        multSum = accHi_q + multExt;
      end
    end else begin
      case ({accLo_q[0], boothBit_q})
        2'b01:   multSum = accHi_q + multExt;
        2'b10:   multSum = accHi_q - multExt;
        default: multSum = accHi_q;
      endcase
      shiftIn = multSum[WIDTH];
    end
  end

  // Restoring-divide step.
  // Shift the next dividend bit into the partial remainder, then try
  // subtracting the divisor. A set top bit on the trial means the
  // subtraction went negative, so the remainder is restored.
  always_comb begin
    remShifted = {accHi_q[WIDTH-1:0], accLo_q[WIDTH-1]};
    remTrial   = remShifted - {1'b0, operand_q};
  end

  // Next-state and datapath control. Everything holds by default. Each
  // state overrides only the registers it owns.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    accHi_d      = accHi_q;
    accLo_d      = accLo_q;
    operand_d    = operand_q;
    boothBit_d   = boothBit_q;
    opIsDiv_d    = opIsDiv_q;
    unsignedOp_d = unsignedOp_q;
    negQuot_d    = negQuot_q;
    negRem_d     = negRem_q;
    divZero_d    = divZero_q;
    hi_d         = hi_q;
    lo_d         = lo_q;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        // Multiply has priority. A simultaneous div_start is dropped.
        if (mult_start) begin
          state_d      = MULT;
          opIsDiv_d    = 1'b0;
          unsignedOp_d = isUnsignedIn;
          operand_d    = a;
          accLo_d      = b;
          accHi_d      = '0;
          boothBit_d   = 1'b0;
          negQuot_d    = 1'b0;
          negRem_d     = 1'b0;
          divZero_d    = 1'b0;
        end else if (div_start) begin
          opIsDiv_d    = 1'b1;
          unsignedOp_d = isUnsignedIn;
          if (b == '0) begin
            // Nothing to compute. Report straight away and leave hi/lo alone.
            state_d   = DONE;
            divZero_d = 1'b1;
          end else begin
            state_d   = DIV;
            accLo_d   = aNeg ? -a : a;
            operand_d = bNeg ? -b : b;
            accHi_d   = '0;
            negQuot_d = aNeg ^ bNeg;
            negRem_d  = aNeg;
            divZero_d = 1'b0;
          end
        end
      end

      MULT: begin
        accHi_d    = {shiftIn, multSum[WIDTH:1]};
        accLo_d    = {multSum[0], accLo_q[WIDTH-1:1]};
        boothBit_d = accLo_q[0];
        cnt_d      = cnt_q + 1'b1;
        if (lastIter) begin
          state_d = FIX;
        end
      end

      DIV: begin
        if (!remTrial[WIDTH]) begin
          accHi_d = remTrial;
          accLo_d = {accLo_q[WIDTH-2:0], 1'b1};
        end else begin
          accHi_d = remShifted;
          accLo_d = {accLo_q[WIDTH-2:0], 1'b0};
        end
        cnt_d = cnt_q + 1'b1;
        if (lastIter) begin
          state_d = FIX;
        end
      end

      FIX: begin
        // The most negative value divided by -1 sees equal signs, so the
        // magnitude quotient 0x80..0 passes through unchanged. That is the
        // wrap result we want, and no exception is raised.
        state_d = DONE;
        if (opIsDiv_q) begin
          lo_d = negQuot_q ? -accLo_q : accLo_q;
          hi_d = negRem_q ? -accHi_q[WIDTH-1:0] : accHi_q[WIDTH-1:0];
        end else begin
          hi_d = accHi_q[WIDTH-1:0];
          lo_d = accLo_q;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers, with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      accHi_q      <= '0;
      accLo_q      <= '0;
      operand_q    <= '0;
      boothBit_q   <= 1'b0;
      opIsDiv_q    <= 1'b0;
      unsignedOp_q <= 1'b0;
      negQuot_q    <= 1'b0;
      negRem_q     <= 1'b0;
      divZero_q    <= 1'b0;
      hi_q         <= '0;
      lo_q         <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      accHi_q      <= accHi_d;
      accLo_q      <= accLo_d;
      operand_q    <= operand_d;
      boothBit_q   <= boothBit_d;
      opIsDiv_q    <= opIsDiv_d;
      unsignedOp_q <= unsignedOp_d;
      negQuot_q    <= negQuot_d;
      negRem_q     <= negRem_d;
      divZero_q    <= divZero_d;
      hi_q         <= hi_d;
      lo_q         <= lo_d;
    end
  end

  assign busy     = (state_q != IDLE);
  assign done     = (state_q == DONE);
  assign div_zero = (state_q == DONE) && divZero_q;
  assign hi       = hi_q;
  assign lo       = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
module tb_mult_div_unit;

  localparam int WIDTH = 32;

  logic              clk;
  logic              reset;
  logic              mult_start;
  logic              div_start;
  logic [WIDTH-1:0]  a;
  logic [WIDTH-1:0]  b;
`ifdef MDU_UNSIGNED_EN
  logic              is_unsigned;
`endif
  logic              busy;
  logic              done;
  logic              div_zero;
  logic [WIDTH-1:0]  hi;
  logic [WIDTH-1:0]  lo;

  int errors = 0;
  int checks = 0;

  logic [WIDTH-1:0]  modelHi = '0;
  logic [WIDTH-1:0]  modelLo = '0;
  logic              modelDz = 1'b0;

  int lat;
  int busyCycles;

  mult_div_unit #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .mult_start (mult_start),
    .div_start  (div_start),
    .a          (a),
    .b          (b),
`ifdef MDU_UNSIGNED_EN
    .is_unsigned(is_unsigned),
`endif
    .busy       (busy),
    .done       (done),
    .div_zero   (div_zero),
    .hi         (hi),
    .lo         (lo)
  );

  // Free-running 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One comparison. A mismatch is counted and reported.
  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Behavioural reference written from the arithmetic definition.
  // Multiply gives the full 64-bit product. Divide uses the language's
  // truncating / and %. A divide by zero leaves hi/lo unchanged.
  task automatic refModel(input bit doMult, input bit uns, input logic [31:0] ra, input logic [31:0] rb);
    logic [63:0] p;
    longint sa, sb, sq, sr;
    logic [63:0] q64, r64;
    modelDz = 1'b0;
    if (doMult) begin
      if (uns) p = {32'b0, ra} * {32'b0, rb};
      else     p = longint'($signed(ra)) * longint'($signed(rb));
      modelHi = p[63:32];
      modelLo = p[31:0];
    end else if (rb == 32'b0) begin
      modelDz = 1'b1;
    end else if (uns) begin
      modelLo = ra / rb;
      modelHi = ra % rb;
    end else begin
      sa = longint'($signed(ra));
      sb = longint'($signed(rb));
      sq = sa / sb;
      sr = sa % sb;
      q64 = sq;
      r64 = sr;
      modelLo = q64[31:0];
      modelHi = r64[31:0];
    end
  endtask

  // Drive one start and wait, with a bound, for done. If injectAt >= 0, a
  // divide-by-zero start is pulsed while the unit is busy; it must be ignored.
  // lat counts edges after the sampling edge until done is seen.
  task automatic applyStimulus(input bit doMult, input bit doDiv, input logic [31:0] sa,
                               input logic [31:0] sb, input bit uns, input int injectAt);
    @(negedge clk);
    mult_start = doMult;
    div_start  = doDiv;
    a = sa;
    b = sb;
`ifdef MDU_UNSIGNED_EN
    is_unsigned = uns;
`endif
    @(negedge clk);
    mult_start = 1'b0;
    div_start  = 1'b0;
    lat = 0;
    busyCycles = 0;
    while (done !== 1'b1 && lat < 100) begin
      if (busy === 1'b1) busyCycles++;
      if (lat == injectAt) begin
        div_start = 1'b1;
        a = 32'h0000_1234;
        b = 32'h0;
      end else begin
        div_start = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
    div_start = 1'b0;
    if (busy === 1'b1) busyCycles++;
  endtask

  // Full operation with every result check. Multiply wins if both starts are high.
  task automatic runAndCheck(input string tag, input bit doMult, input bit doDiv,
                             input logic [31:0] sa, input logic [31:0] sb,
                             input bit uns, input int injectAt);
    bit isDz;
    applyStimulus(doMult, doDiv, sa, sb, uns, injectAt);
    refModel(doMult, uns, sa, sb);
    isDz = !doMult && (sb == 32'b0);
    checkOutput({tag, " latency"}, 64'(lat), isDz ? 64'd0 : 64'(WIDTH + 1));
    checkOutput({tag, " busy cycles"}, 64'(busyCycles), isDz ? 64'd1 : 64'(WIDTH + 2));
    checkOutput({tag, " hi"}, 64'(hi), 64'(modelHi));
    checkOutput({tag, " lo"}, 64'(lo), 64'(modelLo));
    checkOutput({tag, " div_zero"}, 64'(div_zero), 64'(modelDz));
    @(negedge clk);
    checkOutput({tag, " done is a single pulse"}, {62'b0, done, busy}, 64'd0);
  endtask

  initial begin
    int doneSeen;
    logic [31:0] ra, rb;
    bit pickMult;

    reset = 1'b0;
    mult_start = 1'b0;
    div_start = 1'b0;
    a = '0;
    b = '0;
`ifdef MDU_UNSIGNED_EN
    is_unsigned = 1'b0;
`endif

    // Reset state.
    repeat (3) @(negedge clk);
    checkOutput("reset busy", 64'(busy), 64'd0);
    checkOutput("reset done", 64'(done), 64'd0);
    checkOutput("reset div_zero", 64'(div_zero), 64'd0);
    checkOutput("reset hi", 64'(hi), 64'd0);
    checkOutput("reset lo", 64'(lo), 64'd0);
    reset = 1'b1;

    // Directed cases.
    runAndCheck("mult -3*7", 1'b1, 1'b0, 32'hFFFF_FFFD, 32'd7, 1'b0, -1);
    checkOutput("mult -3*7 literal hi", 64'(modelHi), 64'h0000_0000_FFFF_FFFF);
    runAndCheck("div -7/2", 1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2, 1'b0, -1);
    runAndCheck("preload 7/3", 1'b0, 1'b1, 32'd7, 32'd3, 1'b0, -1);
    runAndCheck("div 5/0", 1'b0, 1'b1, 32'd5, 32'd0, 1'b0, -1);
    checkOutput("div 5/0 hi held", 64'(hi), 64'h1);
    checkOutput("div 5/0 lo held", 64'(lo), 64'h2);
    runAndCheck("mult minint^2", 1'b1, 1'b0, 32'h8000_0000, 32'h8000_0000, 1'b0, -1);
    runAndCheck("div minint/-1", 1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, -1);
    runAndCheck("both starts 6*4", 1'b1, 1'b1, 32'd6, 32'd4, 1'b0, -1);
    runAndCheck("div_start while busy", 1'b1, 1'b0, 32'd6, 32'd4, 1'b0, 5);
    runAndCheck("div 7/-2", 1'b0, 1'b1, 32'd7, 32'hFFFF_FFFE, 1'b0, -1);
    runAndCheck("mult minint*-1", 1'b1, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, -1);

    // Reset in the middle of a divide aborts it and clears hi/lo.
    @(negedge clk);
    div_start = 1'b1;
    a = 32'd1000;
    b = 32'd7;
    @(negedge clk);
    div_start = 1'b0;
    repeat (10) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("abort busy", 64'(busy), 64'd0);
    checkOutput("abort hi", 64'(hi), 64'd0);
    checkOutput("abort lo", 64'(lo), 64'd0);
    reset = 1'b1;
    modelHi = '0;
    modelLo = '0;
    doneSeen = 0;
    repeat (40) begin
      @(negedge clk);
      if (done === 1'b1) doneSeen++;
    end
    checkOutput("abort no done", 64'(doneSeen), 64'd0);

    // Randomized signed operations.
    for (int i = 0; i < 24; i++) begin
      ra = $urandom;
      rb = $urandom;
      pickMult = $urandom_range(0, 1) == 1;
      if ($urandom_range(0, 7) == 0) rb = 32'h0;
      if ($urandom_range(0, 5) == 0) rb = $urandom_range(1, 9);
      runAndCheck($sformatf("rand%0d %s", i, pickMult ? "mult" : "div"),
                  pickMult, !pickMult, ra, rb, 1'b0, -1);
    end

`ifdef MDU_UNSIGNED_EN
    runAndCheck("multu max*max", 1'b1, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, -1);
    runAndCheck("divu big/3", 1'b0, 1'b1, 32'hFFFF_FFF9, 32'd3, 1'b1, -1);
    for (int i = 0; i < 8; i++) begin
      ra = $urandom;
      rb = $urandom;
      pickMult = (i % 2) == 0;
      runAndCheck($sformatf("urand%0d", i), pickMult, !pickMult, ra, rb, 1'b1, -1);
    end
    is_unsigned = 1'b0;
`endif

    $display("[TB] Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
